alu_result_stage: RTL and testbench



---
 rtl/alu_result_stage_pkg.sv | 21 ++
 rtl/alu_result_stage_units.sv | 61 ++++++
 rtl/alu_result_stage.sv | 170 +++++++++++++++++
 tb/tb_alu_result_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared types and widths for the ALU result stage and its op units.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_ILL = 2'd3
    } op_e;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } flags_t;

endpackage

// File: rtl/alu_result_stage_units.sv
// Combinational arithmetic units (add, sub, mul) with result flags.

module op_add
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [RES_W-1:0]  y,
    output flags_t            f
);
    logic [DATA_W:0] sum;

    // 9-bit sum, zero-extended; v is signed overflow of the 8-bit add
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        y   = RES_W'(sum);
        f.c = sum[DATA_W];
        f.v = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        f.n = y[DATA_W-1];
        f.z = (y == '0);
    end
endmodule

module op_sub
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [RES_W-1:0]  y,
    output flags_t            f
);
    logic [DATA_W:0] diff;

    // 9-bit difference; carry means "no borrow"
    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        y    = RES_W'(diff);
        f.c  = ~diff[DATA_W];
        f.v  = (a[DATA_W-1] ^ b[DATA_W-1]) & (a[DATA_W-1] ^ diff[DATA_W-1]);
        f.n  = y[DATA_W-1];
        f.z  = (y == '0);
    end
endmodule

module op_mul
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [RES_W-1:0]  y,
    output flags_t            f
);
    // full-width unsigned product; carry/overflow never set
    always_comb begin
        y   = RES_W'(a) * RES_W'(b);
        f.c = 1'b0;
        f.v = 1'b0;
        f.n = y[RES_W-1];
        f.z = (y == '0);
    end
endmodule

// File: rtl/alu_result_stage.sv
// Two-stage issue/retire wrapper around op_add/op_sub/op_mul.
// Optional sticky overflow flag: define ALU_STICKY_OVF_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_y,
    output logic             out_c,
    output logic             out_v,
    output logic             out_n,
    output logic             out_z,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag,
`ifdef ALU_STICKY_OVF_EN
    input  logic             clr_sticky,
    output logic             sticky_v,
`endif
    output logic [CNT_W-1:0] retired
);

    // S1: operand register
    logic              s1_valid;
    op_e               s1_op;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [TAG_W-1:0]  s1_tag;

    // S2: result register
    logic              s2_valid;
    logic [RES_W-1:0]  s2_y;
    flags_t            s2_f;
    logic              s2_err;
    logic [TAG_W-1:0]  s2_tag;

    logic s2_adv;
    logic s1_load;
    logic s1_to_s2;
    logic retire;

    logic [RES_W-1:0] add_y, sub_y, mul_y;
    flags_t           add_f, sub_f, mul_f;

    logic [RES_W-1:0] mux_y;
    flags_t           mux_f;
    logic             mux_err;

    // Handshake / advance decisions; in_ready forced low while in reset
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_to_s2 = s1_valid && s2_adv;
        in_ready = !rst && (!s1_valid || s2_adv);
        s1_load  = in_valid && in_ready;
        retire   = s2_valid && out_ready;
    end

    op_add u_add (.a(s1_a), .b(s1_b), .y(add_y), .f(add_f));
    op_sub u_sub (.a(s1_a), .b(s1_b), .y(sub_y), .f(sub_f));
    op_mul u_mul (.a(s1_a), .b(s1_b), .y(mul_y), .f(mul_f));

    // Select the unit matching the S1 opcode; illegal op yields zeros + err
    always_comb begin
        mux_y   = '0;
        mux_f   = '0;
        mux_err = 1'b0;
        case (s1_op)
            OP_ADD: begin
                mux_y = add_y;
                mux_f = add_f;
            end
            OP_SUB: begin
                mux_y = sub_y;
                mux_f = sub_f;
            end
            OP_MUL: begin
                mux_y = mul_y;
                mux_f = mul_f;
            end
            default: begin
                mux_err = 1'b1;
            end
        endcase
    end

    // S1 register: loads on input handshake, empties when it moves to S2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_op    <= op_e'(in_op);
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_tag   <= in_tag;
            end else if (s1_to_s2) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // S2 register: holds its result until retired downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_f     <= '0;
            s2_err   <= 1'b0;
            s2_tag   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_to_s2) begin
                s2_y   <= mux_y;
                s2_f   <= mux_f;
                s2_err <= mux_err;
                s2_tag <= s1_tag;
            end
        end
    end

    // Retired-result counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

`ifdef ALU_STICKY_OVF_EN
    // Sticky overflow: a setting retire wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_v <= 1'b0;
        end else if (retire && s2_f.v) begin
            sticky_v <= 1'b1;
        end else if (clr_sticky) begin
            sticky_v <= 1'b0;
        end
    end
`endif

    // Outputs come straight from the S2 register
    always_comb begin
        out_valid = s2_valid;
        out_y     = s2_y;
        out_c     = s2_f.c;
        out_v     = s2_f.v;
        out_n     = s2_f.n;
        out_z     = s2_f.z;
        out_err   = s2_err;
        out_tag   = s2_tag;
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage (sticky checks under ALU_STICKY_OVF_EN).
module tb_alu_result_stage;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_y;
    logic             out_c, out_v, out_n, out_z, out_err;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] retired;
`ifdef ALU_STICKY_OVF_EN
    logic             clr_sticky;
    logic             sticky_v;
`endif

    alu_result_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_c     (out_c),
        .out_v     (out_v),
        .out_n     (out_n),
        .out_z     (out_z),
        .out_err   (out_err),
        .out_tag   (out_tag),
`ifdef ALU_STICKY_OVF_EN
        .clr_sticky(clr_sticky),
        .sticky_v  (sticky_v),
`endif
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      y;
        logic [4:0]       fl;   // {c, v, n, z, err}
        logic [TAG_W-1:0] tag;
        int               acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ret_model = 0;
    bit   chk_lat = 1'b0;
    bit   rnd_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model written from the flag definitions using integer arithmetic
    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic [TAG_W-1:0] tag);
        exp_t e;
        int   s, sa;
        logic c, v, n, z, err;
        c = 0; v = 0; n = 0; z = 0; err = 0;
        case (op)
            2'd0: begin
                s   = int'(a) + int'(b);
                e.y = 16'(s);
                c   = (s > 255);
                sa  = int'($signed(a)) + int'($signed(b));
                v   = (sa > 127) || (sa < -128);
                n   = e.y[7];
                z   = (e.y == 16'd0);
            end
            2'd1: begin
                s   = (int'(a) - int'(b)) & 'h1FF;
                e.y = 16'(s);
                c   = (a >= b);
                sa  = int'($signed(a)) - int'($signed(b));
                v   = (sa > 127) || (sa < -128);
                n   = e.y[7];
                z   = (e.y == 16'd0);
            end
            2'd2: begin
                s   = int'(a) * int'(b);
                e.y = 16'(s);
                n   = e.y[15];
                z   = (e.y == 16'd0);
            end
            default: begin
                e.y = 16'd0;
                err = 1'b1;
            end
        endcase
        e.fl      = {c, v, n, z, err};
        e.tag     = tag;
        e.acc_cyc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push on accept, pop/compare on retire, track retired count
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (in_valid && in_ready) begin
                e = model(in_op, in_a, in_b, in_tag);
                e.acc_cyc = cyc;
                sb.push_back(e);
            end
            check("retired", 32'(retired), 32'(ret_model));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_y", 32'(out_y), 32'(e.y));
                    check("out_flags", 32'({out_c, out_v, out_n, out_z, out_err}), 32'(e.fl));
                    check("out_tag", 32'(out_tag), 32'(e.tag));
                    if (chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
                end
                ret_model = ret_model + 1;
            end
        end
    end

    // Drive one operation; returns one tick after the accepting edge
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [TAG_W-1:0] tag);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sb.delete();
        ret_model = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        in_tag    = '0;
        out_ready = 1'b1;
`ifdef ALU_STICKY_OVF_EN
        clr_sticky = 1'b0;
`endif
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_retired", 32'(retired), 32'd0);
        check("reset_out_y", 32'(out_y), 32'd0);
        check("reset_out_misc", 32'({out_c, out_v, out_n, out_z, out_err, out_tag}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_in_ready", 32'(in_ready), 32'd1);

        // Directed arithmetic, back-to-back, latency checked
        chk_lat = 1'b1;
        send(2'd0, 8'h7F, 8'h01, 4'h1);
        send(2'd1, 8'h00, 8'h01, 4'h2);
        send(2'd1, 8'h05, 8'h05, 4'h3);
        send(2'd2, 8'hFF, 8'hFF, 4'h4);
        send(2'd2, 8'h00, 8'h80, 4'h5);
        send(2'd0, 8'hFF, 8'h01, 4'h6);
        send(2'd1, 8'h80, 8'h01, 4'h7);
        wait_drain();
        chk_lat = 1'b0;

        // Backpressure: two accepts fill the stage, then release
        apply_reset();
        out_ready = 1'b0;
        send(2'd0, 8'h01, 8'h02, 4'h1);
        send(2'd1, 8'h09, 8'h03, 4'h2);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        fork
            begin
                send(2'd2, 8'h10, 8'h10, 4'h3);
                send(2'd0, 8'h20, 8'h22, 4'h4);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        @(negedge clk);
        check("bp_retired", 32'(retired), 32'd4);
        @(posedge clk);
        #1;

        // Illegal opcode
        send(2'd3, 8'h12, 8'h34, 4'hA);
        wait_drain();

        // Reset with two operations in flight
        out_ready = 1'b0;
        send(2'd0, 8'h11, 8'h22, 4'h5);
        send(2'd2, 8'h03, 8'h04, 4'h6);
        #2;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), TAG_W'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

`ifdef ALU_STICKY_OVF_EN
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        check("sticky_cleared_pre", 32'(sticky_v), 32'd0);
        send(2'd0, 8'h80, 8'h80, 4'h1);
        wait_drain();
        check("sticky_set", 32'(sticky_v), 32'd1);
        send(2'd0, 8'h01, 8'h01, 4'h2);
        wait_drain();
        check("sticky_persist", 32'(sticky_v), 32'd1);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        check("sticky_clear", 32'(sticky_v), 32'd0);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
